// File: rtl/bt656cap_dma2.sv
// BT.656 capture DMA: packs 32-bit pixel words into ping-pong 32-byte FML write bursts and
// writes whole frames into a ring of nbuf buffers. Define BT656CAP_DMA2_FRAME_COUNT_EN for frame_count.
module bt656cap_dma2 #(
  parameter int fml_depth    = 27,
  parameter int nbuf         = 2,
  parameter int pix_per_word = 2
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 enable,
  input  logic [1:0]           field_filter,
  input  logic [fml_depth-6:0] base_adr,
  input  logic [fml_depth-6:0] frame_bursts,
  input  logic                 v_stb,
  output logic                 v_ack,
  input  logic                 v_field,
  input  logic [31:0]          v_data,
  output logic [fml_depth-1:0] fml_adr,
  output logic                 fml_stb,
  input  logic                 fml_ack,
  output logic [63:0]          fml_do,
  output logic                 in_frame,
  output logic                 start_of_frame,
  output logic                 frame_done,
  output logic                 frame_short,
  output logic [3:0]           cur_buf,
  output logic [15:0]          frame_count
);

  localparam int aw = fml_depth - 5;

  if (nbuf < 1 || nbuf > 16 || pix_per_word < 1 || pix_per_word > 2) begin : g_bad_param
    $error("bt656cap_dma2: nbuf or pix_per_word out of range");
  end

  typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;
  state_t state, state_nxt;

  logic [31:0]   mem [2][8];
  logic [1:0]    full;
  logic          fill_sel, drain_sel;
  logic [2:0]    wr_ptr, wr_idx;
  logic [1:0]    beat, beat_nxt;
  logic          last_field;
  logic [aw-1:0] burst_cnt, frame_base, new_adr, req_adr;
  logic [aw-1:0] buf_adr [2];

  logic field_edge, start, short_frame, store, burst_full, last_burst;
  logic load_req, adr_sel;
  logic [1:0] avail;

  assign v_ack       = sys_rst_n && v_stb && !full[fill_sel];
  assign field_edge  = v_field != last_field;
  assign start       = v_ack && field_edge && enable && field_filter[v_field]
                       && (frame_bursts != '0);
  assign short_frame = v_ack && field_edge && in_frame;
  assign store       = v_ack && (start || (in_frame && !field_edge));
  assign burst_full  = store && !start && (wr_ptr == 3'd7);
  assign last_burst  = burst_full && (burst_cnt == frame_bursts - aw'(1));
  assign wr_idx      = start ? 3'd0 : wr_ptr;
  assign new_adr     = frame_base + burst_cnt;
  assign beat_nxt    = beat + 2'd1;

  // A buffer completing this very cycle counts as full so the request goes out one cycle sooner.
  assign avail[0] = full[0] | (burst_full & ~fill_sel);
  assign avail[1] = full[1] | (burst_full & fill_sel);
  assign req_adr  = full[adr_sel] ? buf_adr[adr_sel] : new_adr;
  assign fml_stb  = (state == REQ);

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  // NOTE: every variable driven here gets a default first, so no latch can be inferred.
  always_comb begin
    state_nxt = state;
    load_req  = 1'b0;
    adr_sel   = drain_sel;
    unique case (state)
      IDLE: if (avail[drain_sel]) begin
        state_nxt = REQ;
        load_req  = 1'b1;
      end
      REQ:  if (fml_ack) state_nxt = DATA;
      DATA: if (beat == 2'd3) begin
        if (avail[~drain_sel]) begin
          state_nxt = REQ;
          load_req  = 1'b1;
          adr_sel   = ~drain_sel;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: burst storage is plain RAM with no reset; the full flags alone say what is valid.
  always_ff @(posedge sys_clk) begin
    if (store) mem[fill_sel][wr_idx] <= v_data;
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      last_field     <= 1'b0;
      in_frame       <= 1'b0;
      start_of_frame <= 1'b0;
      frame_done     <= 1'b0;
      frame_short    <= 1'b0;
      cur_buf        <= 4'd0;
      frame_base     <= base_adr;
      burst_cnt      <= '0;
      wr_ptr         <= 3'd0;
      fill_sel       <= 1'b0;
      drain_sel      <= 1'b0;
      full           <= 2'b00;
      buf_adr[0]     <= '0;
      buf_adr[1]     <= '0;
      beat           <= 2'd0;
      fml_adr        <= '0;
      fml_do         <= '0;
    end else begin
      start_of_frame <= start;
      frame_short    <= short_frame;
      frame_done     <= last_burst;
      if (v_ack) last_field <= v_field;

      if (start) begin
        in_frame  <= 1'b1;
        burst_cnt <= '0;
        wr_ptr    <= 3'd1;
      end else if (short_frame) begin
        in_frame <= 1'b0;
        wr_ptr   <= 3'd0;
      end else if (burst_full) begin
        wr_ptr            <= 3'd0;
        fill_sel          <= ~fill_sel;
        full[fill_sel]    <= 1'b1;
        buf_adr[fill_sel] <= new_adr;
        burst_cnt         <= burst_cnt + aw'(1);
        if (last_burst) begin
          in_frame <= 1'b0;
          if (cur_buf == 4'(nbuf - 1)) begin
            cur_buf    <= 4'd0;
            frame_base <= base_adr;
          end else begin
            cur_buf    <= cur_buf + 4'd1;
            frame_base <= frame_base + frame_bursts;
          end
        end
      end else if (store) begin
        wr_ptr <= wr_ptr + 3'd1;
      end

      if (load_req) fml_adr <= {req_adr, 5'b0};
      if (state == REQ && fml_ack) begin
        beat   <= 2'd0;
        fml_do <= {mem[drain_sel][0], mem[drain_sel][1]};
      end else if (state == DATA) begin
        if (beat == 2'd3) begin
          full[drain_sel] <= 1'b0;
          drain_sel       <= ~drain_sel;
        end else begin
          beat   <= beat_nxt;
          fml_do <= {mem[drain_sel][{beat_nxt, 1'b0}], mem[drain_sel][{beat_nxt, 1'b1}]};
        end
      end
    end
  end

`ifdef BT656CAP_DMA2_FRAME_COUNT_EN
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n)      frame_count <= 16'd0;
    else if (last_burst) frame_count <= frame_count + 16'd1;
  end
`else
  assign frame_count = 16'd0;
`endif

endmodule

// File: tb/tb_bt656cap_dma2.sv
// Scoreboard bench for bt656cap_dma2: a frame-level reference model predicts bursts and pulses,
// independent monitors compare what the DUT presents on the FML and status ports.
module tb_bt656cap_dma2;

  localparam int FML_DEPTH = 27;
  localparam int NBUF      = 2;
  localparam int AW        = FML_DEPTH - 5;

  logic                 sys_clk, sys_rst_n, enable, v_stb, v_ack, v_field, fml_stb, fml_ack;
  logic [1:0]           field_filter;
  logic [AW-1:0]        base_adr, frame_bursts;
  logic [31:0]          v_data;
  logic [FML_DEPTH-1:0] fml_adr;
  logic [63:0]          fml_do;
  logic                 in_frame, start_of_frame, frame_done, frame_short;
  logic [3:0]           cur_buf;
  logic [15:0]          frame_count;

  bt656cap_dma2 #(.fml_depth(FML_DEPTH), .nbuf(NBUF), .pix_per_word(2)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .enable(enable), .field_filter(field_filter),
    .base_adr(base_adr), .frame_bursts(frame_bursts), .v_stb(v_stb), .v_ack(v_ack),
    .v_field(v_field), .v_data(v_data), .fml_adr(fml_adr), .fml_stb(fml_stb),
    .fml_ack(fml_ack), .fml_do(fml_do), .in_frame(in_frame), .start_of_frame(start_of_frame),
    .frame_done(frame_done), .frame_short(frame_short), .cur_buf(cur_buf),
    .frame_count(frame_count)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [FML_DEPTH-1:0] adr;
    logic [3:0][63:0]     beats;
  } burst_t;

  localparam logic [1:0] EV_START = 2'd0, EV_SHORT = 2'd1, EV_DONE = 2'd2;
  typedef struct packed {
    logic [1:0]  kind;
    logic [3:0]  buf_idx;
    logic [15:0] count;
  } ev_t;

  burst_t exp_bursts[$];
  ev_t    exp_events[$];

  // Reference model: frames are lists of words; every 8 words become one burst at
  // base + ring_index * stride + burst_number.
  bit          m_last_field, m_in_frame;
  logic [31:0] m_words[$];
  int          m_burst, m_buf, m_frames;

  function automatic void push_event(input logic [1:0] kind);
    ev_t e;
    e.kind    = kind;
    e.buf_idx = 4'(m_buf);
`ifdef BT656CAP_DMA2_FRAME_COUNT_EN
    e.count = 16'(m_frames);
`else
    e.count = 16'd0;
`endif
    exp_events.push_back(e);
  endfunction

  function automatic void model_consume(input logic f, input logic [31:0] d);
    bit     fe;
    burst_t b;
    longint a;
    fe = (f != m_last_field);
    m_last_field = f;
    if (fe && m_in_frame) begin
      push_event(EV_SHORT);
      m_in_frame = 0;
      m_words.delete();
    end
    if (fe && enable && field_filter[f] && frame_bursts != 0) begin
      push_event(EV_START);
      m_in_frame = 1;
      m_burst    = 0;
      m_words.delete();
    end
    if (!m_in_frame) return;
    m_words.push_back(d);
    if (m_words.size() == 8) begin
      a = longint'(base_adr) + longint'(m_buf) * longint'(frame_bursts) + longint'(m_burst);
      b.adr = {a[AW-1:0], 5'b0};
      for (int k = 0; k < 4; k++) b.beats[k] = {m_words[2*k], m_words[2*k+1]};
      exp_bursts.push_back(b);
      m_words.delete();
      m_burst++;
      if (m_burst == int'(frame_bursts)) begin
        m_in_frame = 0;
        m_buf      = (m_buf + 1) % NBUF;
        m_frames++;
        push_event(EV_DONE);
      end
    end
  endfunction

  function automatic void model_reset();
    m_last_field = 0;
    m_in_frame   = 0;
    m_burst      = 0;
    m_buf        = 0;
    m_frames     = 0;
    m_words.delete();
    exp_bursts.delete();
    exp_events.delete();
  endfunction

  // FML slave: random acceptance latency, or none at all while hold_ack is set.
  bit hold_ack = 0;
  initial begin
    fml_ack = 1'b0;
    forever begin
      @(posedge sys_clk);
      #1;
      fml_ack = fml_stb && !hold_ack && ($urandom_range(0, 3) != 0);
    end
  end

  // Burst monitor.
  int mon_beat = 3;
  bit mon_busy = 0;
  initial begin
    burst_t b;
    forever begin
      @(negedge sys_clk);
      if (sys_rst_n && fml_stb && fml_ack) begin
        check("burst_expected", exp_bursts.size() != 0, 1'b1);
        if (exp_bursts.size() != 0) begin
          b = exp_bursts.pop_front();
          check("fml_adr", fml_adr, b.adr);
          mon_busy = 1;
          mon_beat = -1;
          for (int k = 0; k < 4; k++) begin
            @(negedge sys_clk);
            if (!sys_rst_n) break;
            check("fml_do_beat", fml_do, b.beats[k]);
            mon_beat = k;
          end
          mon_busy = 0;
        end
      end
    end
  end

  // Pulse monitor.
  task automatic take_event(input logic [1:0] kind, output ev_t e, output bit ok);
    ok = exp_events.size() != 0;
    check("pulse_expected", ok, 1'b1);
    e = '0;
    if (ok) begin
      e = exp_events.pop_front();
      check("pulse_kind", kind, e.kind);
    end
  endtask

  initial begin
    ev_t e;
    bit  ok;
    forever begin
      @(negedge sys_clk);
      if (sys_rst_n) begin
        if (frame_short) take_event(EV_SHORT, e, ok);
        if (start_of_frame) begin
          take_event(EV_START, e, ok);
          check("in_frame_at_start", in_frame, 1'b1);
        end
        if (frame_done) begin
          take_event(EV_DONE, e, ok);
          check("in_frame_at_done", in_frame, 1'b0);
          if (ok) begin
            check("cur_buf_at_done", cur_buf, e.buf_idx);
            check("frame_count_at_done", frame_count, e.count);
          end
        end
      end
    end
  end

  bit gaps_en = 1;

  task automatic send_word(input logic f, input logic [31:0] d);
    bit got = 0;
    v_field = f;
    v_data  = d;
    v_stb   = 1'b1;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge sys_clk);
      if (v_ack) got = 1;
    end
    check("v_ack_within_budget", got, 1'b1);
    if (got) begin
      model_consume(f, d);
      @(posedge sys_clk);
      #1;
    end
    v_stb = 1'b0;
    if (gaps_en) repeat ($urandom_range(0, 1)) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic send_words(input logic f, input int n, input bit seq, input logic [31:0] first);
    for (int i = 0; i < n; i++) send_word(f, seq ? first + 32'(i) : $urandom());
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge sys_clk);
      done = (exp_bursts.size() == 0) && (exp_events.size() == 0) && !mon_busy && !fml_stb;
    end
    check("drain_complete", done, 1'b1);
  endtask

  task automatic do_reset();
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int  acks;
    bit  found;
    sys_rst_n    = 1'b0;
    enable       = 1'b1;
    field_filter = 2'b01;
    base_adr     = 22'h100;
    frame_bursts = 22'd3;
    v_field      = 1'b0;
    v_data       = 32'h0;
    v_stb        = 1'b1;
    model_reset();
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check("rst_v_ack", v_ack, 1'b0);
    check("rst_fml_stb", fml_stb, 1'b0);
    check("rst_fml_adr", fml_adr, '0);
    check("rst_fml_do", fml_do, '0);
    check("rst_in_frame", in_frame, 1'b0);
    check("rst_pulses", {start_of_frame, frame_done, frame_short}, 3'b000);
    check("rst_cur_buf", cur_buf, 4'd0);
    check("rst_frame_count", frame_count, 16'd0);
    v_stb = 1'b0;
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;

    // Basic frame: words 0..23 after a 1->0 field edge.
    send_word(1'b1, $urandom());
    send_words(1'b0, 24, 1'b1, 32'h0);
    check("basic_cur_buf", cur_buf, 4'd1);
    check("basic_in_frame", in_frame, 1'b0);

    // Ring wrap: two more frames.
    for (int fr = 1; fr <= 2; fr++) begin
      send_word(1'b1, $urandom());
      send_word(1'b0, $urandom());
      check("wrap_cur_buf_in_frame", cur_buf, 4'(fr % 2));
      send_words(1'b0, 23, 1'b0, 32'h0);
    end
    check("wrap_cur_buf_end", cur_buf, 4'd1);
    wait_idle();
`ifdef BT656CAP_DMA2_FRAME_COUNT_EN
    check("wrap_frame_count", frame_count, 16'd3);
`else
    check("wrap_frame_count", frame_count, 16'd0);
`endif

    // Backpressure: both burst buffers fill, input must stall.
    hold_ack = 1;
    send_word(1'b1, $urandom());
    send_words(1'b0, 16, 1'b0, 32'h0);
    v_field = 1'b0;
    v_data  = 32'hCAFE0016;
    v_stb   = 1'b1;
    acks    = 0;
    repeat (40) begin
      @(negedge sys_clk);
      if (v_ack) acks++;
    end
    check("bp_v_ack_low", acks, 0);
    check("bp_fml_stb_held", fml_stb, 1'b1);
    hold_ack = 0;
    send_word(1'b0, 32'hCAFE0016);
    send_words(1'b0, 7, 1'b0, 32'h0);

    // Field filter: field-0 edges ignored, field-1 edge starts the frame.
    enable = 1'b0;
    send_word(1'b1, $urandom());
    enable       = 1'b1;
    field_filter = 2'b10;
    send_words(1'b0, 6, 1'b0, 32'h0);
    check("filter_no_frame", in_frame, 1'b0);
    send_word(1'b1, $urandom());
    check("filter_frame_started", in_frame, 1'b1);
    send_words(1'b1, 23, 1'b0, 32'h0);
    wait_idle();

    // Reset during DATA beat 1.
    field_filter = 2'b01;
    gaps_en      = 0;
    send_word(1'b1, $urandom());
    send_words(1'b0, 8, 1'b0, 32'h0);
    check("stb_after_8th_word", fml_stb, 1'b1);
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(posedge sys_clk);
      if (mon_beat == 0) found = 1;
    end
    check("reached_beat1", found, 1'b1);
    #1;
    sys_rst_n = 1'b0;
    model_reset();
    @(negedge sys_clk);
    @(negedge sys_clk);
    check("mid_rst_fml_stb", fml_stb, 1'b0);
    check("mid_rst_fml_adr", fml_adr, '0);
    check("mid_rst_fml_do", fml_do, '0);
    check("mid_rst_in_frame", in_frame, 1'b0);
    check("mid_rst_cur_buf", cur_buf, 4'd0);
    check("mid_rst_frame_count", frame_count, 16'd0);
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    gaps_en   = 1;

    // Short frame: 12 words, then an edge that also starts the next frame.
    field_filter = 2'b11;
    send_word(1'b1, $urandom());
    send_words(1'b1, 11, 1'b0, 32'h0);
    send_word(1'b0, $urandom());
    check("short_cur_buf_kept", cur_buf, 4'd0);
    check("short_restarted", in_frame, 1'b1);
    send_words(1'b0, 23, 1'b0, 32'h0);
    check("short_next_cur_buf", cur_buf, 4'd1);
    wait_idle();

    // Burst address wraps at the top of the address space.
    base_adr = 22'h3FFFFE;
    do_reset();
    field_filter = 2'b01;
    send_word(1'b1, $urandom());
    send_words(1'b0, 24, 1'b0, 32'h0);
    wait_idle();

    // Zero-length frames never start.
    frame_bursts = '0;
    send_word(1'b1, $urandom());
    send_words(1'b0, 5, 1'b0, 32'h0);
    check("zero_bursts_no_frame", in_frame, 1'b0);

    // Random soak: random filters, random frame lengths (many short).
    frame_bursts = 22'd2;
    base_adr     = 22'(22'h155 + $urandom_range(0, 255));
    do_reset();
    for (int it = 0; it < 10; it++) begin
      field_filter = 2'($urandom_range(1, 3));
      send_words(1'(it % 2 == 0), $urandom_range(1, 20), 1'b0, 32'h0);
    end
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bt656cap_dma2.md
# bt656cap_dma2

Parametrised successor to the BT.656 capture DMA engine. Single `sys_clk` domain. Packs pixel words from the video input stage into FML write bursts, ping-pong buffered so capture continues during a burst. Writes whole frames into a ring of `nbuf` frame buffers, advancing automatically. Sits between `bt656cap_input` and the FML arbiter; control/status wires go to the control interface.

## Interface
- `fml_depth`, 27, FML byte-address width.
- `nbuf`, 2, frame buffers in the ring (1..16).
- `pix_per_word`, 2, pixels per 32-bit input word (2 = RGB565, 1 = RGB888-in-32); informational only, no datapath effect.

Ports:
- `sys_clk` in 1: single clock.
- `sys_rst_n` in 1: reset, synchronous, active-low.
- `enable` in 1: arm capture; sampled only at frame start.
- `field_filter` in 2: bit0 accepts field 0, bit1 accepts field 1.
- `base_adr` in fml_depth-5: burst address of buffer 0.
- `frame_bursts` in fml_depth-5: bursts per frame, also the buffer stride.
- `v_stb` in 1: input word valid.
- `v_ack` out 1: input word consumed.
- `v_field` in 1: field of the current word.
- `v_data` in 32: pixel word.
- `fml_adr` out fml_depth: burst address; low 5 bits always 0.
- `fml_stb` out 1: burst request.
- `fml_ack` in 1: burst accepted.
- `fml_do` out 64: write data.
- `in_frame` out 1: a frame is being captured.
- `start_of_frame` out 1: one-cycle pulse.
- `frame_done` out 1: one-cycle pulse.
- `frame_short` out 1: one-cycle pulse.
- `cur_buf` out 4: buffer index being written, or the next to be written when idle.
- `frame_count` out 16: completed-frame counter (see Configuration).

## Operation
- Packing: 8 consecutive 32-bit words form one 32-byte burst. Word pair 2k/2k+1 becomes `fml_do` beat k, with word 2k on bits [63:32].
- Two burst buffers, A and B. Input fills one while the other drains to FML. `v_ack = v_stb && fill buffer not full`. Words are always consumed; they are stored only when `in_frame=1`.
- Field tracking: register `last_field` holds `v_field` from the last consumed word. A field edge is a consumed word whose `v_field != last_field`.
- Frame start happens on a field edge when `enable=1` and `field_filter[v_field]=1`:
  - `in_frame<=1`, pulse `start_of_frame`.
  - Burst counter cleared; the fill pointer restarts at word 0.
  - The edge word is stored as word 0.
- Buffer addressing: register `frame_base` resets to `base_adr`. The burst address is `frame_base + burst_cnt`, computed with a `fml_depth-5`-bit add, overflow discarded. No multiplier.
- Frame completion: when burst `frame_bursts-1` is handed to the drain side:
  - `in_frame<=0`, pulse `frame_done`.
  - `cur_buf` increments. At `nbuf-1` it wraps to 0 and `frame_base<=base_adr`; otherwise `frame_base<=frame_base+frame_bursts`.
- Short frame: a field edge while `in_frame=1` before completion:
  - Pulse `frame_short`; the partially filled burst is discarded.
  - `cur_buf` and `frame_base` are unchanged, so the buffer is reused.
  - The same edge word may immediately start a new frame under the start rule. `frame_short` and `start_of_frame` then pulse in the same cycle.
- `frame_bursts=0`: capture never starts; `start_of_frame` is suppressed.
- FSM (drain side), states IDLE, REQ, DATA:
  - IDLE→REQ when a full burst buffer exists.
  - REQ holds `fml_stb=1` with a stable `fml_adr` until `fml_ack`.
  - REQ→DATA on `fml_ack`.
  - DATA emits 4 beats, then returns to IDLE, or to REQ if the other buffer is full.
- Reset mid-burst abandons the burst; no further `fml_stb` is driven.

## Timing
- Reset values: `v_ack`=0, `fml_stb`=0, `fml_adr`=0, `fml_do`=0, `in_frame`=0, pulses 0, `cur_buf`=0, `frame_count`=0, `frame_base`=`base_adr`, `last_field`=0.
- `fml_stb` rises the cycle after the 8th word of a burst is consumed, provided the FSM is in IDLE.
- Beat 0 appears on `fml_do` the cycle after `fml_ack`; beats 1-3 follow on consecutive cycles.
- The drained buffer is freed the cycle after beat 3. `v_ack` may reassert into it that same cycle.
- Worst case with both buffers full: `v_ack`=0 until the first buffer frees.
- Pulses are one cycle, registered, and coincide with the `in_frame` transition.

## Configuration
- `BT656CAP_DMA2_FRAME_COUNT_EN`:
  - Defined: `frame_count` is a 16-bit counter incremented on each `frame_done`, wrapping 0xFFFF→0; reset to 0.
  - Undefined: `frame_count` is constant 0 and no counter logic is built.

## Test plan
- Basic frame, `nbuf=2`, `base_adr`=0x100, `frame_bursts`=3, filter=2'b01:
  - Stimulus: field edge 1→0, then 24 words 0x00000000..0x00000017.
  - Required: 3 bursts at `fml_adr` 0x2000, 0x2020, 0x2040; beat 0 of burst 0 = 0x0000000000000001.
  - Required: then `frame_done`, `cur_buf`=1.
- Ring wrap: three consecutive frames.
  - Required: frame bases 0x100, 0x103, 0x100; `cur_buf` sequence 0,1,0.
  - Required: `frame_count`=3 with the macro, 0 without.
- Backpressure: hold `fml_ack`=0 for 40 cycles during a frame.
  - Required: `v_ack` drops after 16 buffered words; no word lost or duplicated after release.
- Field filter = 2'b10:
  - Stimulus: field 0 edges.
  - Required: no `start_of_frame` and no `fml_stb`; words still acked.
  - Required: the next field 1 edge starts the frame.
- Short frame: field edge after 12 words with `frame_bursts`=3.
  - Required: 1 burst written, `frame_short` pulse, the new frame restarts at 0x2000, `cur_buf` unchanged.
- Reset: `sys_rst_n`=0 during DATA beat 1.
  - Required: all outputs return to reset values the next cycle; a fresh frame after reset starts at `base_adr`.
